multi_debouncer: RTL and testbench

- N-channel synchronizing debouncer for raw push-buttons and switches; next generation of the single-channel debouncer.
- Adds per-channel polarity, a shared tick prescaler, one-cycle press/release pulses, long-press detection and a synchronous reset.
- Sits between board pins and the control FSMs of the final-project top level.

---
 rtl/debounce_pkg.sv | 24 ++
 rtl/debounce_channel.sv | 136 +++++++++++++
 rtl/multi_debouncer.sv | 57 +++++
 tb/tb_multi_debouncer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the debouncer family: per-channel FSM encoding and
// a constant-friendly ceil(log2) used to size counters.
package debounce_pkg;

   typedef enum logic [1:0] {
      LOW     = 2'd0,
      WAIT_HI = 2'd1,
      HIGH    = 2'd2,
      WAIT_LO = 2'd3
   } deb_state_t;

   // ceil(log2(value)); 0 and 1 both give 0
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 32; i++) begin
         if ((longint'(1) << i) < longint'(value)) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: two-flop synchronizer, polarity fix, stability FSM
// and registered rise/fall/long-press pulses. Timing is paced by a shared tick.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int   STABLE_TICKS = 8,
   parameter int   LONG_TICKS   = 64,
   parameter logic INVERT       = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic btn,
   output logic level,
   output logic rise,
   output logic fall,
   output logic long_press
);

   localparam int CW = clog2(STABLE_TICKS) + 1;
   localparam int HW = clog2(LONG_TICKS) + 1;
   localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_TICKS);
   localparam logic [HW-1:0] LONG_MAX   = HW'(LONG_TICKS);

   logic          s0, s1, x;
   deb_state_t    state, state_n;
   logic [CW-1:0] cnt, cnt_n, cnt_inc, cnt_first;
   logic [HW-1:0] hold, hold_n, hold_inc;
   logic          rise_n, fall_n, long_n;

   assign x         = s1 ^ INVERT;
   assign cnt_inc   = cnt + CW'(1);
   assign hold_inc  = hold + HW'(1);
   assign cnt_first = tick ? CW'(1) : '0;

   // Glitches abort a pending transition on any cycle; counting only advances on ticks.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      hold_n  = hold;
      rise_n  = 1'b0;
      fall_n  = 1'b0;
      long_n  = 1'b0;
      case (state)
         LOW: begin
            if (x) begin
               if (cnt_first >= STABLE_MAX) begin
                  state_n = HIGH;
                  cnt_n   = '0;
                  hold_n  = '0;
                  rise_n  = 1'b1;
               end else begin
                  state_n = WAIT_HI;
                  cnt_n   = cnt_first;
               end
            end
         end
         WAIT_HI: begin
            if (!x) begin
               state_n = LOW;
               cnt_n   = '0;
            end else if (tick) begin
               if (cnt_inc >= STABLE_MAX) begin
                  state_n = HIGH;
                  cnt_n   = '0;
                  hold_n  = '0;
                  rise_n  = 1'b1;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
         end
         HIGH: begin
            if (tick && (hold < LONG_MAX)) begin
               hold_n = hold_inc;
               long_n = (hold_inc == LONG_MAX);
            end
            if (!x) begin
               if (cnt_first >= STABLE_MAX) begin
                  state_n = LOW;
                  cnt_n   = '0;
                  fall_n  = 1'b1;
                  long_n  = 1'b0;
               end else begin
                  state_n = WAIT_LO;
                  cnt_n   = cnt_first;
               end
            end
         end
         WAIT_LO: begin
            // hold is frozen here so a bounce cannot re-arm long_press
            if (x) begin
               state_n = HIGH;
               cnt_n   = '0;
            end else if (tick) begin
               if (cnt_inc >= STABLE_MAX) begin
                  state_n = LOW;
                  cnt_n   = '0;
                  fall_n  = 1'b1;
               end else begin
                  cnt_n = cnt_inc;
               end
            end
         end
         default: begin
            state_n = LOW;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s0         <= 1'b0;
         s1         <= 1'b0;
         state      <= LOW;
         cnt        <= '0;
         hold       <= '0;
         level      <= 1'b0;
         rise       <= 1'b0;
         fall       <= 1'b0;
         long_press <= 1'b0;
      end else begin
         s0         <= btn;
         s1         <= s0;
         state      <= state_n;
         cnt        <= cnt_n;
         hold       <= hold_n;
         level      <= (state_n == HIGH) || (state_n == WAIT_LO);
         rise       <= rise_n;
         fall       <= fall_n;
         long_press <= long_n;
      end
   end

endmodule

// File: rtl/multi_debouncer.sv
// N-channel debouncer: one shared tick prescaler feeding independent
// per-channel debounce engines.
module multi_debouncer
   import debounce_pkg::*;
#(
   parameter int                  CHANNELS     = 4,
   parameter int                  STABLE_TICKS = 8,
   parameter int                  LONG_TICKS   = 64,
   parameter int                  TICK_DIV     = 1,
   parameter logic [CHANNELS-1:0] INVERT_MASK  = '0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] btn,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] long_press
);

   localparam int PW = clog2(TICK_DIV) + 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] pre_cnt;
   logic          tick;

   // With TICK_DIV=1 the counter sits at zero and tick stays high
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt <= '0;
      end else if (pre_cnt >= PRE_LAST) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PW'(1);
      end
   end

   assign tick = (pre_cnt == PRE_LAST);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      debounce_channel #(
         .STABLE_TICKS(STABLE_TICKS),
         .LONG_TICKS  (LONG_TICKS),
         .INVERT      (INVERT_MASK[i])
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .tick      (tick),
         .btn       (btn[i]),
         .level     (level[i]),
         .rise      (rise[i]),
         .fall      (fall[i]),
         .long_press(long_press[i])
      );
   end

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: a pulse scoreboard fed at stimulus time, a
// table of multi-channel levels, and hand sequences for timing corners.
`timescale 1ns/1ps
module tb_multi_debouncer;

   localparam int K_RISE = 0;
   localparam int K_FALL = 1;
   localparam int K_LONG = 2;
   localparam logic [3:0] IDLE2 = 4'b0010;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn, btn2;
   logic [3:0] level, rise, fall, long_press;
   logic [3:0] level_d, rise_d, fall_d, long_d;

   always #5 clk = ~clk;

   multi_debouncer #(
      .CHANNELS(4), .STABLE_TICKS(8), .LONG_TICKS(64), .TICK_DIV(1), .INVERT_MASK(4'b0000)
   ) dut (
      .clk(clk), .rst(rst), .btn(btn),
      .level(level), .rise(rise), .fall(fall), .long_press(long_press)
   );

   multi_debouncer #(
      .CHANNELS(4), .STABLE_TICKS(8), .LONG_TICKS(64), .TICK_DIV(4), .INVERT_MASK(4'b0010)
   ) dut_div (
      .clk(clk), .rst(rst), .btn(btn2),
      .level(level_d), .rise(rise_d), .fall(fall_d), .long_press(long_d)
   );

   typedef struct {
      int dut;
      int ch;
      int kind;
      int at;
   } evt_t;

   typedef struct {
      logic [3:0] btn;
      logic [3:0] exp_level;
   } vec_t;

   evt_t       sb[$];
   vec_t       tbl[5];
   int         cyc = 0;
   int         last_rst = 0;
   int         checks = 0;
   int         errors = 0;
   logic [3:0] prev_level;
   int         p, q, t;

   // Posedge numbering; remembers the last posedge that saw reset
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) last_rst <= cyc + 1;
   end

   function automatic string kind_name(input int k);
      if (k == K_RISE) return "rise";
      if (k == K_FALL) return "fall";
      return "long_press";
   endfunction

   function automatic logic [3:0] pulse_of(input int d, input int k);
      if (d == 0) begin
         if (k == K_RISE) return rise;
         if (k == K_FALL) return fall;
         return long_press;
      end
      if (k == K_RISE) return rise_d;
      if (k == K_FALL) return fall_d;
      return long_d;
   endfunction

   // Every observed pulse must match a queued expectation; stale expectations are misses
   always @(negedge clk) begin : monitor
      logic [3:0] pv;
      int         idx;
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 3; k++) begin
            pv = pulse_of(d, k);
            for (int c = 0; c < 4; c++) begin
               if (pv[c] !== 1'b0) begin
                  idx = -1;
                  foreach (sb[i]) begin
                     if (sb[i].dut == d && sb[i].ch == c && sb[i].kind == k && sb[i].at == cyc) idx = i;
                  end
                  checks++;
                  if (idx >= 0) begin
                     sb.delete(idx);
                  end else begin
                     errors++;
                     $display("[TB] FAIL unexpected_%s dut%0d ch%0d posedge %0d: got %b, required 0",
                              kind_name(k), d, c, cyc, pv[c]);
                  end
               end
            end
         end
      end
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].at <= cyc) begin
            checks++;
            errors++;
            $display("[TB] FAIL missing_%s dut%0d ch%0d: got no pulse by posedge %0d, required at posedge %0d",
                     kind_name(sb[i].kind), sb[i].dut, sb[i].ch, cyc, sb[i].at);
            sb.delete(i);
         end
      end
   end

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic expect_evt(input int d, input int c, input int k, input int at);
      evt_t e;
      e.dut  = d;
      e.ch   = c;
      e.kind = k;
      e.at   = at;
      sb.push_back(e);
   endtask

   task automatic applyStimulus(input logic [3:0] b, input logic [3:0] b2);
      btn  = b;
      btn2 = b2;
   endtask

   task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %b, required %b", name, actual, expected);
      end
   endtask

   // Posedge at which a TICK_DIV=4 channel accepts a level first sampled at 'first'
   function automatic int div_event(input int first);
      int pp, n;
      pp = first + 2;
      n  = 0;
      for (int g = 0; g < 200; g++) begin
         if (pp > last_rst && ((pp - last_rst) % 4) == 0) n++;
         if (n == 8) return pp;
         pp++;
      end
      return -1;
   endfunction

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion by 200us, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      tbl[0] = '{4'b0000, 4'b0000};
      tbl[1] = '{4'b0101, 4'b0101};
      tbl[2] = '{4'b1111, 4'b1111};
      tbl[3] = '{4'b1010, 4'b1010};
      tbl[4] = '{4'b0000, 4'b0000};

      rst = 1'b1;
      applyStimulus(4'b0000, IDLE2);
      wait_until(3);
      rst = 1'b0;
      checkOutput("reset_level",  level, 4'b0000);
      checkOutput("reset_rise",   rise,  4'b0000);
      checkOutput("reset_long",   long_press, 4'b0000);
      checkOutput("reset_level2", level_d, 4'b0000);
      wait_until(10);

      // Table: hold each pattern long enough to settle, then check levels
      prev_level = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(tbl[i].btn, IDLE2);
         for (int c = 0; c < 4; c++) begin
            if (tbl[i].exp_level[c] != prev_level[c])
               expect_evt(0, c, tbl[i].exp_level[c] ? K_RISE : K_FALL, cyc + 10);
         end
         wait_until(cyc + 14);
         checkOutput($sformatf("table%0d_level", i), level, tbl[i].exp_level);
         prev_level = tbl[i].exp_level;
      end

      // Clean press: first sample p, level/rise visible after p+9 only
      applyStimulus(4'b0001, IDLE2);
      p = cyc + 1;
      expect_evt(0, 0, K_RISE, p + 9);
      wait_until(p + 8);
      checkOutput("press_level_early", level, 4'b0000);
      wait_until(p + 9);
      checkOutput("press_level", level, 4'b0001);
      checkOutput("press_rise",  rise,  4'b0001);
      wait_until(p + 10);
      checkOutput("press_rise_cleared", rise, 4'b0000);
      applyStimulus(4'b0000, IDLE2);
      expect_evt(0, 0, K_FALL, cyc + 10);
      wait_until(cyc + 12);

      // Bounce on press: high p, low p+4, high p+6 held -> rise at p+15
      applyStimulus(4'b0001, IDLE2);
      p = cyc + 1;
      wait_until(p + 3);
      applyStimulus(4'b0000, IDLE2);
      wait_until(p + 5);
      applyStimulus(4'b0001, IDLE2);
      expect_evt(0, 0, K_RISE, p + 15);
      wait_until(p + 14);
      checkOutput("bounce_level_early", level, 4'b0000);
      wait_until(p + 15);
      checkOutput("bounce_level", level, 4'b0001);

      // Release with two 3-cycle glitches, low held from q+10 -> fall at q+19
      q = cyc + 1;
      applyStimulus(4'b0000, IDLE2);
      wait_until(q + 2);
      applyStimulus(4'b0001, IDLE2);
      wait_until(q + 4);
      applyStimulus(4'b0000, IDLE2);
      wait_until(q + 7);
      applyStimulus(4'b0001, IDLE2);
      wait_until(q + 9);
      checkOutput("release_glitch_level", level, 4'b0001);
      applyStimulus(4'b0000, IDLE2);
      expect_evt(0, 0, K_FALL, q + 19);
      wait_until(q + 18);
      checkOutput("release_level_early", level, 4'b0001);
      wait_until(q + 20);
      checkOutput("release_level", level, 4'b0000);

      // Long press on ch2, then a 3-cycle release glitch while still held
      applyStimulus(4'b0100, IDLE2);
      p = cyc + 1;
      expect_evt(0, 2, K_RISE, p + 9);
      expect_evt(0, 2, K_LONG, p + 73);
      wait_until(p + 72);
      checkOutput("long_not_yet", long_press, 4'b0000);
      wait_until(p + 73);
      checkOutput("long_pulse", long_press, 4'b0100);
      wait_until(p + 80);
      applyStimulus(4'b0000, IDLE2);
      wait_until(p + 83);
      applyStimulus(4'b0100, IDLE2);
      wait_until(p + 110);
      checkOutput("long_glitch_level", level, 4'b0100);
      applyStimulus(4'b0000, IDLE2);
      expect_evt(0, 2, K_FALL, cyc + 10);
      wait_until(cyc + 12);

      // Reset mid-press on ch1 with the button still held
      applyStimulus(4'b0010, IDLE2);
      p = cyc + 1;
      expect_evt(0, 1, K_RISE, p + 9);
      wait_until(p + 12);
      checkOutput("prereset_level", level, 4'b0010);
      rst = 1'b1;
      q = cyc + 1;
      wait_until(q);
      rst = 1'b0;
      checkOutput("midreset_level", level, 4'b0000);
      checkOutput("midreset_fall",  fall,  4'b0000);
      checkOutput("midreset_rise",  rise,  4'b0000);
      expect_evt(0, 1, K_RISE, q + 10);
      wait_until(q + 9);
      checkOutput("postreset_level_early", level, 4'b0000);
      wait_until(q + 10);
      checkOutput("postreset_level", level, 4'b0010);
      applyStimulus(4'b0000, IDLE2);
      expect_evt(0, 1, K_FALL, cyc + 10);
      wait_until(cyc + 12);

      // TICK_DIV=4 instance: all channels active at once, ch1 active-low
      applyStimulus(4'b0000, 4'b1101);
      t = div_event(cyc + 1);
      for (int c = 0; c < 4; c++) expect_evt(1, c, K_RISE, t);
      wait_until(t - 1);
      checkOutput("div_level_early", level_d, 4'b0000);
      wait_until(t);
      checkOutput("div_level", level_d, 4'b1111);
      wait_until(t + 3);
      applyStimulus(4'b0000, 4'b1111);
      t = div_event(cyc + 1);
      expect_evt(1, 1, K_FALL, t);
      wait_until(t);
      checkOutput("div_release_ch1", level_d, 4'b1101);
      wait_until(t + 2);
      applyStimulus(4'b0000, IDLE2);
      t = div_event(cyc + 1);
      for (int c = 0; c < 4; c++) if (c != 1) expect_evt(1, c, K_FALL, t);
      wait_until(t);
      checkOutput("div_release_all", level_d, 4'b0000);
      checkOutput("div_idle_dut0", level, 4'b0000);

      wait_until(cyc + 5);
      foreach (sb[i]) begin
         checks++;
         errors++;
         $display("[TB] FAIL pending_%s dut%0d ch%0d: got none, required at posedge %0d",
                  kind_name(sb[i].kind), sb[i].dut, sb[i].ch, sb[i].at);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
